// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake/control bundle between the pipeline and its stall/flush sequencer.
// The slave side is the sequencer; the master side is the CPU datapath.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             MemRead_i;
    logic             MemWrite_i;
    logic             hit_i;
    logic             mem_ack_i;
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_Rt_i;
    logic [4:0]       IFID_Rs_i;
    logic [4:0]       IFID_Rt_i;
    logic             branch_taken_i;
    logic             mem_req_o;
    logic             pipe_stall_o;
    logic             pc_write_o;
    logic             ifid_stall_o;
    logic             idex_bubble_o;
    logic             ifid_flush_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output MemRead_i, MemWrite_i, hit_i, mem_ack_i, IDEX_MemRead_i,
               IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, branch_taken_i,
        input  mem_req_o, pipe_stall_o, pc_write_o, ifid_stall_o,
               idex_bubble_o, ifid_flush_o, err_o, stall_cnt_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, hit_i, mem_ack_i, IDEX_MemRead_i,
               IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, branch_taken_i,
        output mem_req_o, pipe_stall_o, pc_write_o, ifid_stall_o,
               idex_bubble_o, ifid_flush_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Priority: D-cache miss freeze > load-use bubble > taken-branch flush.
// A miss runs a REQ/WAIT/RESUME refill handshake with a timeout that
// forces resume and raises a sticky error.
// Optional: define STALL_PERF_CNT_EN to count frozen cycles on stall_cnt_o;
// otherwise stall_cnt_o is tied to zero.
module pipeline_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    pipeline_stall_ctrl_if.slave bus
);
    localparam int WC_RAW = $clog2(TIMEOUT + 1);
    localparam int WC_W   = (WC_RAW > 8) ? WC_RAW : 8;
    localparam logic [WC_W-1:0] TO_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESUME} state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              err_q, err_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              miss, hazard, stall;

    // Gating with rst_n_i keeps every combinational output at its idle value
    // while reset is held, regardless of what the datapath presents.
    assign miss   = rst_n_i & (state_q == IDLE) &
                    (bus.MemRead_i | bus.MemWrite_i) & ~bus.hit_i;
    assign hazard = rst_n_i & bus.IDEX_MemRead_i & (bus.IDEX_Rt_i != 5'd0) &
                    ((bus.IDEX_Rt_i == bus.IFID_Rs_i) |
                     (bus.IDEX_Rt_i == bus.IFID_Rt_i));
    // Freeze is combinational so it lands in the very cycle the miss is seen.
    assign stall  = miss | (state_q != IDLE);

    assign bus.pipe_stall_o  = stall;
    assign bus.pc_write_o    = ~stall & ~hazard;
    assign bus.ifid_stall_o  = ~stall & hazard;
    assign bus.idex_bubble_o = ~stall & hazard;
    assign bus.ifid_flush_o  = ~stall & ~hazard & bus.branch_taken_i;
    assign bus.mem_req_o     = mem_req_q;
    assign bus.err_o         = err_q;

    // Refill FSM next-state, wait counter and sticky timeout flag.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d    = REQ;
                    wait_cnt_d = '0;
                end
            end
            REQ: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                state_d    = bus.mem_ack_i ? RESUME : WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (bus.mem_ack_i) begin
                    state_d = RESUME;
                end else if (wait_cnt_q == TO_LAST) begin
                    state_d = RESUME;
                    err_d   = 1'b1;
                end
            end
            // One cycle for the cache to re-read the refilled line.
            RESUME:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_req_d = (state_d == REQ) || (state_d == WAIT);
    end

    // State, registered request and error flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of frozen cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign bus.stall_cnt_o = cnt_q;
`else
    assign bus.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: hazard/branch vector table,
// directed miss/timeout/reset sequences, then randomized traffic against an
// event-time reference model.
module tb_pipeline_stall_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 32;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: a miss occupies the cycles from detection until the
    // end of the request window, plus one resume cycle.
    int              cyc;
    bit              busy;      // a miss has been accepted and is not finished
    int              miss_t;    // cycle the miss was detected
    int              req_end;   // last cycle of the request window, -1 if open
    bit              m_err;
    longint unsigned m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy = 0; req_end = -1; miss_t = 0; m_err = 0; m_cnt = 0; cyc = 0;
    endtask

    task automatic zero_inputs();
        bus.MemRead_i = 0; bus.MemWrite_i = 0; bus.hit_i = 1; bus.mem_ack_i = 0;
        bus.IDEX_MemRead_i = 0; bus.IDEX_Rt_i = 0; bus.IFID_Rs_i = 0;
        bus.IFID_Rt_i = 0; bus.branch_taken_i = 0;
    endtask

    // One clock: check every output mid-cycle against the model, then advance.
    task automatic cycle(input string tag);
        bit miss_now, haz, e_stall;
        logic [63:0] e_cnt;
        #3;
        miss_now = !busy && (bus.MemRead_i || bus.MemWrite_i) && !bus.hit_i;
        e_stall  = busy || miss_now;
        haz = bus.IDEX_MemRead_i && bus.IDEX_Rt_i != 0 &&
              (bus.IDEX_Rt_i == bus.IFID_Rs_i || bus.IDEX_Rt_i == bus.IFID_Rt_i);
`ifdef STALL_PERF_CNT_EN
        e_cnt = m_cnt;
`else
        e_cnt = 0;
`endif
        chk({tag, ".stall"},  bus.pipe_stall_o, e_stall);
        chk({tag, ".req"},    bus.mem_req_o, busy && req_end < 0);
        chk({tag, ".pcw"},    bus.pc_write_o, !e_stall && !haz);
        chk({tag, ".ifid_st"},bus.ifid_stall_o, !e_stall && haz);
        chk({tag, ".bubble"}, bus.idex_bubble_o, !e_stall && haz);
        chk({tag, ".flush"},  bus.ifid_flush_o, !e_stall && !haz && bus.branch_taken_i);
        chk({tag, ".err"},    bus.err_o, m_err);
        chk({tag, ".cnt"},    64'(bus.stall_cnt_o), e_cnt);
        @(posedge clk_i);
        if (e_stall) m_cnt++;
        if (!busy) begin
            if (miss_now) begin busy = 1; miss_t = cyc; req_end = -1; end
        end else if (req_end < 0) begin
            if (bus.mem_ack_i) req_end = cyc;
            else if (cyc - miss_t == TIMEOUT) begin req_end = cyc; m_err = 1; end
        end else begin
            busy = 0;
        end
        cyc++;
        #1;
    endtask

    // Directed cycle: hard expectations from the timing rules, then model check.
    task automatic dcyc(input string tag, input bit e_stall, input bit e_req, input bit e_err);
        #2;
        chk({tag, ".d_stall"}, bus.pipe_stall_o, e_stall);
        chk({tag, ".d_req"},   bus.mem_req_o, e_req);
        chk({tag, ".d_err"},   bus.err_o, e_err);
        #(-0);
        cycle(tag);
    endtask

    task automatic do_reset();
        rst_n_i = 0;
        zero_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.stall", bus.pipe_stall_o, 0);
        chk("rst.req",   bus.mem_req_o, 0);
        chk("rst.pcw",   bus.pc_write_o, 1);
        chk("rst.err",   bus.err_o, 0);
        chk("rst.cnt",   64'(bus.stall_cnt_o), 0);
        rst_n_i = 1;
    endtask

    typedef struct {
        bit ex_mr; logic [4:0] ex_rt; logic [4:0] rs; logic [4:0] rt; bit br;
        bit mr; bit e_pcw; bit e_haz; bit e_fl;
    } vec_t;
    vec_t vt[$];
    longint unsigned cnt0;

    initial begin
        zero_inputs();
        model_reset();
        do_reset();

        // Hazard / branch vector table (FSM idle, optional load that hits).
        vt.push_back('{1, 5,  5,  0,  0, 0, 0, 1, 0});
        vt.push_back('{1, 0,  0,  0,  0, 0, 1, 0, 0});
        vt.push_back('{1, 5,  0,  5,  0, 0, 0, 1, 0});
        vt.push_back('{1, 5,  5,  0,  1, 0, 0, 1, 0});
        vt.push_back('{0, 0,  0,  0,  1, 0, 1, 0, 1});
        vt.push_back('{0, 5,  5,  5,  0, 1, 1, 0, 0});
        vt.push_back('{1, 7,  3,  4,  1, 1, 1, 0, 1});
        vt.push_back('{1, 31, 31, 31, 0, 1, 0, 1, 0});
        for (int i = 0; i < vt.size(); i++) begin
            bus.IDEX_MemRead_i = vt[i].ex_mr; bus.IDEX_Rt_i = vt[i].ex_rt;
            bus.IFID_Rs_i = vt[i].rs; bus.IFID_Rt_i = vt[i].rt;
            bus.branch_taken_i = vt[i].br; bus.MemRead_i = vt[i].mr; bus.hit_i = 1;
            #2;
            chk($sformatf("vec%0d.pcw", i),    bus.pc_write_o, vt[i].e_pcw);
            chk($sformatf("vec%0d.ifid", i),   bus.ifid_stall_o, vt[i].e_haz);
            chk($sformatf("vec%0d.bubble", i), bus.idex_bubble_o, vt[i].e_haz);
            chk($sformatf("vec%0d.flush", i),  bus.ifid_flush_o, vt[i].e_fl);
            chk($sformatf("vec%0d.stall", i),  bus.pipe_stall_o, 0);
            cycle($sformatf("vec%0d", i));
        end
        zero_inputs();

        // Miss at N, ack at N+4: stall N..N+5, req N+1..N+4, idle at N+6.
        cnt0 = m_cnt;
        bus.MemRead_i = 1; bus.hit_i = 0;
        dcyc("ack.n0", 1, 0, 0);
        dcyc("ack.n1", 1, 1, 0);
        dcyc("ack.n2", 1, 1, 0);
        dcyc("ack.n3", 1, 1, 0);
        bus.mem_ack_i = 1;
        dcyc("ack.n4", 1, 1, 0);
        bus.mem_ack_i = 0; bus.hit_i = 1;
        dcyc("ack.n5", 1, 0, 0);
        dcyc("ack.n6", 0, 0, 0);
`ifdef STALL_PERF_CNT_EN
        chk("ack.cnt6", 64'(bus.stall_cnt_o), cnt0 + 6);
`endif
        zero_inputs();

        // Miss with hazard in the same cycle: only the freeze shows.
        bus.MemWrite_i = 1; bus.hit_i = 0;
        bus.IDEX_MemRead_i = 1; bus.IDEX_Rt_i = 9; bus.IFID_Rt_i = 9;
        #2;
        chk("mh.bubble", bus.idex_bubble_o, 0);
        chk("mh.pcw", bus.pc_write_o, 0);
        cycle("mh0");
        bus.mem_ack_i = 1;
        cycle("mh1");
        bus.mem_ack_i = 0; bus.hit_i = 1; bus.MemWrite_i = 0;
        cycle("mh2");
        cycle("mh3");
        zero_inputs();

        // No ack: timeout forces resume, error sticks.
        bus.MemRead_i = 1; bus.hit_i = 0;
        dcyc("to.n0", 1, 0, 0);
        dcyc("to.n1", 1, 1, 0);
        dcyc("to.n2", 1, 1, 0);
        dcyc("to.n3", 1, 1, 0);
        dcyc("to.n4", 1, 1, 0);
        bus.hit_i = 1;
        dcyc("to.n5", 1, 0, 1);
        bus.MemRead_i = 0;
        dcyc("to.n6", 0, 0, 1);
        dcyc("to.n7", 0, 0, 1);

        // Reset asserted in WAIT: request drops without a clock edge.
        bus.MemRead_i = 1; bus.hit_i = 0;
        cycle("rw0");
        cycle("rw1");
        bus.IDEX_MemRead_i = 1; bus.IDEX_Rt_i = 5; bus.IFID_Rs_i = 5;
        #2;
        chk("rw.pre_req", bus.mem_req_o, 1);
        rst_n_i = 0;
        #1;
        chk("rw.req",   bus.mem_req_o, 0);
        chk("rw.stall", bus.pipe_stall_o, 0);
        chk("rw.pcw",   bus.pc_write_o, 1);
        chk("rw.bub",   bus.idex_bubble_o, 0);
        chk("rw.err",   bus.err_o, 0);
        zero_inputs();
        model_reset();
        bus.mem_ack_i = 1;
        @(posedge clk_i);
        #1;
        rst_n_i = 1;
        cycle("rw.ack_ign");
        bus.mem_ack_i = 0;
        cycle("rw.after");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.MemRead_i      = ($urandom % 3) == 0;
            bus.MemWrite_i     = ($urandom % 5) == 0;
            bus.hit_i          = ($urandom % 3) != 0;
            bus.mem_ack_i      = ($urandom % 4) == 0;
            bus.IDEX_MemRead_i = $urandom % 2;
            bus.IDEX_Rt_i      = 5'($urandom % 4);
            bus.IFID_Rs_i      = 5'($urandom % 4);
            bus.IFID_Rt_i      = 5'($urandom % 4);
            bus.branch_taken_i = $urandom % 2;
            cycle($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Drives the hold inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. Resolves three events by priority: data-cache miss (global freeze, FSM-sequenced refill handshake), load-use hazard (bubble into ID/EX), taken branch (flush IF/ID). Sits beside the hazard unit in the CPU top; its output feeds directly into each pipeline register's `stall_i`.

## Interface
- `TIMEOUT`, 255: max cycles waiting for `mem_ack_i` before forced resume and error flag.
- `CNT_W`, 32: width of stall-cycle counter.

- `clk_i` in 1: clock, rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `MemRead_i` in 1: MEM-stage load.
- `MemWrite_i` in 1: MEM-stage store.
- `hit_i` in 1: D-cache hit for current MEM access.
- `mem_ack_i` in 1: lower memory refill/writeback done, 1-cycle pulse.
- `IDEX_MemRead_i` in 1: instruction in EX is a load.
- `IDEX_Rt_i` in 5: load destination in EX.
- `IFID_Rs_i`, `IFID_Rt_i` in 5 each: source registers of instruction in ID.
- `branch_taken_i` in 1: branch resolved taken in ID.
- `mem_req_o` out 1: refill request to lower memory, level.
- `pipe_stall_o` out 1: global freeze; wired to every pipeline register `stall_i`.
- `pc_write_o` out 1: PC update enable.
- `ifid_stall_o` out 1: hold IF/ID (load-use only).
- `idex_bubble_o` out 1: zero ID/EX control signals.
- `ifid_flush_o` out 1: clear IF/ID instruction.
- `err_o` out 1: sticky timeout flag.
- `stall_cnt_o` out CNT_W: cycles with `pipe_stall_o`=1.

## Operation
- FSM states: IDLE, REQ, WAIT, RESUME.
- `miss` = state IDLE & (`MemRead_i`|`MemWrite_i`) & ~`hit_i`.
- IDLE: `miss` → REQ; else stay.
- REQ: `mem_ack_i` → RESUME; else WAIT.
- WAIT: `mem_ack_i` → RESUME; `wait_cnt`==TIMEOUT-1 → RESUME and set `err_o`; else stay.
- RESUME: → IDLE unconditionally (one cycle for cache to re-read refilled line).
- `mem_req_o` = registered; 1 exactly while state is REQ or WAIT.
- `wait_cnt` (8-bit min, ceil(log2(TIMEOUT+1))): cleared entering REQ, increments each cycle in REQ/WAIT.
- `pipe_stall_o` = `miss` | (state ≠ IDLE); combinational so freeze takes effect in the miss-detect cycle.
- `hazard` = `IDEX_MemRead_i` & (`IDEX_Rt_i`≠0) & (`IDEX_Rt_i`==`IFID_Rs_i` | `IDEX_Rt_i`==`IFID_Rt_i`).
- Priority: `pipe_stall_o` > `hazard` > `branch_taken_i`.
- `pc_write_o` = ~`pipe_stall_o` & ~`hazard`.
- `ifid_stall_o` = `idex_bubble_o` = ~`pipe_stall_o` & `hazard`.
- `ifid_flush_o` = ~`pipe_stall_o` & ~`hazard` & `branch_taken_i`.
- `err_o` sticky; cleared only by reset.
- `mem_ack_i` in IDLE or RESUME ignored.

## Timing
- Reset (async, `rst_n_i`=0): state IDLE, `mem_req_o`=0, `err_o`=0, `wait_cnt`=0, `stall_cnt_o`=0; combinational outputs forced `pipe_stall_o`=0, `ifid_stall_o`=0, `idex_bubble_o`=0, `ifid_flush_o`=0, `pc_write_o`=1.
- Miss at cycle N: `pipe_stall_o`=1 in N; `mem_req_o`=1 from N+1.
- Ack at cycle M (M≥N+1): `mem_req_o`=0 from M+1; RESUME in M+1 (stall still 1); IDLE in M+2, stall released if access now hits.
- Minimum miss penalty: 3 stall cycles (ack in REQ).
- Reset mid-miss: FSM returns to IDLE immediately; `mem_req_o` drops asynchronously.
- Miss and hazard same cycle: only `pipe_stall_o` asserted; hazard re-evaluated after release.

## Configuration
- `STALL_PERF_CNT_EN` defined: `stall_cnt_o` increments every cycle `pipe_stall_o`=1, saturates at 2^CNT_W−1, reset to 0.
- Undefined: counter logic omitted, `stall_cnt_o` tied to 0; port still present.

## Test plan
- Load hit (`MemRead_i`=1, `hit_i`=1) → `pipe_stall_o`=0, `mem_req_o` never 1, FSM stays IDLE.
- Load miss at cycle 10, `mem_ack_i` pulse at cycle 14 → `pipe_stall_o`=1 cycles 10–15, `mem_req_o`=1 cycles 11–14, IDLE at 16; with macro `stall_cnt_o`=6.
- No ack, TIMEOUT=4, miss at cycle 0 → `mem_req_o` cycles 1–4, RESUME cycle 5, `err_o`=1 from cycle 5 and stays 1.
- `IDEX_MemRead_i`=1, `IDEX_Rt_i`=5, `IFID_Rs_i`=5 → `pc_write_o`=0, `ifid_stall_o`=1, `idex_bubble_o`=1; same with `IDEX_Rt_i`=0 → no hazard.
- Hazard + `branch_taken_i` same cycle → `ifid_flush_o`=0; branch alone → `ifid_flush_o`=1, `pc_write_o`=1.
- `rst_n_i` low during WAIT → `mem_req_o`=0 and state IDLE without clock edge; later ack ignored.
